// File: rtl/vga_bus_pkg.sv
// Shared bus constants and arbiter state type for the VGA Wishbone slice.
package vga_bus_pkg;

    localparam int WB_DAT_W  = 32;
    localparam int WB_SEL_W  = 4;
    localparam int VGA_ADR_W = 12;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester after 'last', wrapping.
module rr_picker #(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [$clog2(NUM_MASTERS)-1:0] last,
    output logic                           valid,
    output logic [$clog2(NUM_MASTERS)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    // Scan offsets 1..NUM_MASTERS from the previous owner; first hit wins.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        valid    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
            cand     = (32'(last) + off) % NUM_MASTERS;
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/vga_wb_arbiter.sv
// Round-robin Wishbone classic arbiter in front of the VGA framebuffer slave.
// Optional stall abort enabled by defining WB_ARB_TIMEOUT_EN.
module vga_wb_arbiter
    import vga_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADR_W          = VGA_ADR_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i,
    input  logic [ADR_W*NUM_MASTERS-1:0]    m_adr_i,
    input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [WB_SEL_W-1:0]             s_sel_o,
    output logic [ADR_W-1:0]                s_adr_o,
    output logic [WB_DAT_W-1:0]             s_dat_o,
    input  logic                            s_ack_i,
    output logic [$clog2(NUM_MASTERS)-1:0]  grant_o,
    output logic                            busy_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] last_grant, last_nxt, grant_nxt;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    logic                own_cyc, own_stb, own_we;
    logic [WB_SEL_W-1:0] own_sel;
    logic [ADR_W-1:0]    own_adr;
    logic [WB_DAT_W-1:0] own_dat;
    logic                timeout;

    rr_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .req  (m_cyc_i),
        .last (last_grant),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    // Select the current owner's bus signals; other masters never reach the slave.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (grant_o == IDX_W'(k)) begin
                own_cyc = m_cyc_i[k];
                own_stb = m_stb_i[k];
                own_we  = m_we_i[k];
                own_sel = m_sel_i[WB_SEL_W*k +: WB_SEL_W];
                own_adr = m_adr_i[ADR_W*k +: ADR_W];
                own_dat = m_dat_i[WB_DAT_W*k +: WB_DAT_W];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] stall_cnt;

    // Count owned cycles where the strobe waits without an ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (state != ARB_OWNED || s_ack_i || timeout) begin
            stall_cnt <= '0;
        end else if (own_stb) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign timeout = (state == ARB_OWNED) && (stall_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ARB_IDLE;
            grant_o    <= '0;
            last_grant <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state      <= state_nxt;
            grant_o    <= grant_nxt;
            last_grant <= last_nxt;
        end
    end

    // Next-state logic and slave/master-side outputs.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_o;
        last_nxt  = last_grant;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_nxt = pick_idx;
                    state_nxt = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                s_we_o  = own_we;
                s_sel_o = own_sel;
                s_adr_o = own_adr;
                s_dat_o = own_dat;
                if (timeout) begin
                    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
                        m_err_o[k] = (grant_o == IDX_W'(k));
                    end
                    last_nxt  = grant_o;
                    state_nxt = ARB_IDLE;
                end else begin
                    s_cyc_o = own_cyc;
                    s_stb_o = own_stb;
                    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
                        m_ack_o[k] = (grant_o == IDX_W'(k)) && s_ack_i;
                    end
                    if (!own_cyc) begin
                        last_nxt  = grant_o;
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign busy_o = (state == ARB_OWNED);

endmodule

// File: tb/tb_vga_wb_arbiter.sv
// Directed self-checking bench for vga_wb_arbiter (two masters, timeout of 8).
module tb_vga_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
    logic [7:0]  m_sel = '0;
    logic [23:0] m_adr = '0;
    logic [63:0] m_dat = '0;
    logic [1:0]  m_ack, m_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [11:0] s_adr;
    logic [31:0] s_dat;
    logic        s_ack = 1'b0;
    logic [0:0]  grant;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    vga_wb_arbiter #(
        .NUM_MASTERS(2),
        .ADR_W(12),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .m_cyc_i(m_cyc),
        .m_stb_i(m_stb),
        .m_we_i (m_we),
        .m_sel_i(m_sel),
        .m_adr_i(m_adr),
        .m_dat_i(m_dat),
        .m_ack_o(m_ack),
        .m_err_o(m_err),
        .s_cyc_o(s_cyc),
        .s_stb_o(s_stb),
        .s_we_o (s_we),
        .s_sel_o(s_sel),
        .s_adr_o(s_adr),
        .s_dat_o(s_dat),
        .s_ack_i(s_ack),
        .grant_o(grant),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_scyc", s_cyc, 0);
        chk("rst_sstb", s_stb, 0);
        chk("rst_ack", m_ack, 0);
        chk("rst_err", m_err, 0);
        rst = 1'b0;
        step();

        // 1. Single master write; master 1 drives decoy values that must not leak
        m_adr = {12'hABC, 12'h010};
        m_dat = {32'h12345678, 32'hDEADBEEF};
        m_sel = {4'h3, 4'hF};
        m_we  = 2'b01;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        #1;
        chk("t1_idle_scyc", s_cyc, 0);
        step();
        chk("t1_scyc", s_cyc, 1);
        chk("t1_sstb", s_stb, 1);
        chk("t1_busy", busy, 1);
        chk("t1_grant", grant, 0);
        chk("t1_adr", s_adr, 12'h010);
        chk("t1_dat", s_dat, 32'hDEADBEEF);
        chk("t1_sel", s_sel, 4'hF);
        chk("t1_we", s_we, 1);
        chk("t1_noack", m_ack, 2'b00);
        s_ack = 1'b1;
        #1;
        chk("t1_ack", m_ack, 2'b01);
        step();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #1;
        chk("t1_rel_scyc", s_cyc, 0);
        chk("t1_rel_ack", m_ack, 2'b00);
        step();
        chk("t1_idle_busy", busy, 0);

        // 2. Contention after reset: grants alternate 0,1,0,1 with a dead cycle
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_busy", busy, 1);
            chk("t2_grant", grant, i % 2);
            chk("t2_ack_none", m_ack, 2'b00);
            m_cyc[i % 2] = 1'b0;
            #1;
            chk("t2_rel_scyc", s_cyc, 0);
            step();
            chk("t2_dead", busy, 0);
            m_cyc[i % 2] = 1'b1;
        end

        // 3. Master 1 keeps the bus for three strobes while master 0 waits
        do_reset();
        m_adr = {12'h100, 12'h777};
        m_we  = 2'b10;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        step();
        chk("t3_grant1", grant, 1);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_adr[23:12] = 12'h100 + 12'(k);
            #1;
            chk("t3_adr", s_adr, 12'h100 + 12'(k));
            s_ack = 1'b1;
            #1;
            chk("t3_ack1", m_ack, 2'b10);
            step();
            s_ack = 1'b0;
            m_stb[1] = 1'b0;
            #1;
            chk("t3_hold_grant", grant, 1);
            chk("t3_hold_busy", busy, 1);
            chk("t3_ack0_quiet", m_ack, 2'b00);
            step();
            m_stb[1] = 1'b1;
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        step();
        chk("t3_dead", busy, 0);
        step();
        chk("t3_grant0", grant, 0);
        chk("t3_busy0", busy, 1);

        // 4. Reset while master 0 owns the bus with stb high and ack asserted
        s_ack = 1'b1;
        #1;
        chk("t4_pre_ack", m_ack, 2'b01);
        rst = 1'b1;
        #1;
        chk("t4_scyc", s_cyc, 0);
        chk("t4_sstb", s_stb, 0);
        chk("t4_busy", busy, 0);
        chk("t4_ack", m_ack, 2'b00);
        rst = 1'b0; s_ack = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11;
        step();
        chk("t4_prio", grant, 0);

        // 5. Slave never acks
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        step();
        chk("t5_grant0", grant, 0);
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 0; c < 8; c++) begin
            chk("t5_no_err", m_err, 2'b00);
            chk("t5_scyc_on", s_cyc, 1);
            step();
        end
        chk("t5_err", m_err, 2'b01);
        chk("t5_scyc_off", s_cyc, 0);
        chk("t5_sstb_off", s_stb, 0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        step();
        chk("t5_err_pulse", m_err, 2'b00);
        chk("t5_dead", busy, 0);
        step();
        chk("t5_grant1", grant, 1);
`else
        for (int c = 0; c < 12; c++) begin
            chk("t5_no_err", m_err, 2'b00);
            chk("t5_hold", busy, 1);
            step();
        end
        chk("t5_still_owner", grant, 0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        step();
        chk("t5_dead", busy, 0);
        step();
        chk("t5_grant1", grant, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
